// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencer that runs one counting job on a loadable up-counter.
// Optional build macro: COUNTER_CTRL_AUTO_RELOAD_EN (repeat the job until abort/rst).
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   start               job request, honoured only when idle
//   start_val/stop_val  first and terminal count, captured on accepted start
//   abort               cancel the job in flight, no done
//   cnt_out             counter value fed back from the counter
//   load, enab, cnt_in  drive the counter's load/enable/parallel input
//   busy                a job is in progress
//   done                one-cycle registered completion pulse
module counter_ctrl #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] stop_val,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_out,
    output logic             load,
    output logic             enab,
    output logic [WIDTH-1:0] cnt_in,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_in_q, cnt_in_d;
    logic [WIDTH-1:0] stop_q, stop_d;
    logic             done_q, done_d;
    logic             match;

    assign match = (cnt_out == stop_q);

    always_comb begin
        state_d  = state_q;
        cnt_in_d = cnt_in_q;
        stop_d   = stop_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    cnt_in_d = start_val;
                    stop_d   = stop_val;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                state_d = abort ? IDLE : RUN;
            end
            RUN: begin
                // abort wins over a coincident match: no done on cancel
                if (abort) begin
                    state_d = IDLE;
                end else if (match) begin
                    done_d  = 1'b1;
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
                    state_d = LOAD;
`else
                    state_d = DONE;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_in_q <= '0;
            stop_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_in_q <= cnt_in_d;
            stop_q   <= stop_d;
            done_q   <= done_d;
        end
    end

    assign load   = (state_q == LOAD);
    // Drop enab on match so the counter parks on stop_val
    assign enab   = (state_q == RUN) && !match && !abort;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign cnt_in = cnt_in_q;

endmodule
